// File: rtl/writeback_commit_unit.sv
// writeback_commit_unit: stage-5 commit of the stage-4 control word.
// Commits register-file, stack-pointer, output-port and memory-write effects.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  control-word handshake (transfer when both high)
//   wr..ern            control bits of the committing instruction
//   rn, port_sel       register index / output port index
//   result, addr_in    load value / non-stack write address
//   rf_rd_sel/_data    asynchronous register-file read
//   sp, out_ports      stack pointer, flattened output port registers
//   mem_wr_*           registered write request with ack handshake
//   mem_err            one-cycle pulse when a write times out
//   sp_fault           sticky stack over/underflow flag (STACK_GUARD_EN only)
//
// Optional feature: define STACK_GUARD_EN to enable stack bound checking.

module writeback_commit_unit #(
    parameter logic [7:0] SP_RESET  = 8'hFF,
    parameter int         NUM_PORTS = 8,
    parameter int         WAIT_MAX  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   wr,
    input  logic                   lrn,
    input  logic                   lr0,
    input  logic                   lsp,
    input  logic                   dsp,
    input  logic                   isp,
    input  logic                   lop,
    input  logic                   ern,
    input  logic [2:0]             rn,
    input  logic [2:0]             port_sel,
    input  logic [7:0]             result,
    input  logic [7:0]             addr_in,
    input  logic [2:0]             rf_rd_sel,
    output logic [7:0]             rf_rd_data,
    output logic [7:0]             sp,
    output logic [8*NUM_PORTS-1:0] out_ports,
    output logic                   mem_wr_req,
    output logic [7:0]             mem_addr,
    output logic [7:0]             mem_wr_data,
    input  logic                   mem_wr_ack,
    output logic                   mem_err
`ifdef STACK_GUARD_EN
    ,
    output logic                   sp_fault
`endif
);

    localparam int CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e          state_q, state_d;
    logic [7:0]      rf_q [8];
    logic [7:0]      rf_d [8];
    logic [7:0]      port_q [NUM_PORTS];
    logic [7:0]      port_d [NUM_PORTS];
    logic [7:0]      sp_q, sp_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            req_q, req_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fault_q, fault_d;

    logic accept;
    logic sp_dec;
    logic sp_inc;
    logic guard_hit;
    logic start_wr;
    logic wait_done;

    assign accept = in_valid & in_ready;
    assign sp_dec = ~lsp & dsp & ~isp;
    assign sp_inc = ~lsp & isp & ~dsp;

`ifdef STACK_GUARD_EN
    assign guard_hit = (sp_dec & (sp_q == 8'h00)) |
                       (sp_inc & (sp_q == 8'hFF));
    assign sp_fault  = fault_q;
`else
    assign guard_hit = 1'b0;
`endif

    // A guarded push must not write below the stack floor.
    assign start_wr  = wr & ~(guard_hit & sp_dec);
    // Ack wins over timeout when both happen in the same cycle.
    assign wait_done = mem_wr_ack | (cnt_q == CNT_LAST);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept && start_wr) state_d = S_WAIT;
            S_WAIT: if (wait_done)          state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state_q == S_IDLE);
    end

    // Datapath next-state
    always_comb begin
        rf_d    = rf_q;
        port_d  = port_q;
        sp_d    = sp_q;
        addr_d  = addr_q;
        data_d  = data_q;
        req_d   = req_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        fault_d = fault_q | (accept & guard_hit);
        if (accept) begin
            if (lrn) rf_d[rn] = result;
            if (lr0) rf_d[0]  = result;
            if (lsp)                    sp_d = result;
            else if (sp_dec & ~guard_hit) sp_d = sp_q - 8'd1;
            else if (sp_inc & ~guard_hit) sp_d = sp_q + 8'd1;
            if (lop && (int'(port_sel) < NUM_PORTS))
                port_d[port_sel] = result;
            if (start_wr) begin
                // Address and data use pre-update sp and rf.
                addr_d = dsp ? (sp_q - 8'd1) : addr_in;
                data_d = ern ? rf_q[rn] : result;
                req_d  = 1'b1;
                cnt_d  = '0;
            end
        end else if (state_q == S_WAIT) begin
            if (mem_wr_ack) begin
                req_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
                req_d = 1'b0;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            for (int k = 0; k < NUM_PORTS; k++) port_q[k] <= '0;
            sp_q    <= SP_RESET;
            addr_q  <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            rf_q    <= rf_d;
            port_q  <= port_d;
            sp_q    <= sp_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            req_q   <= req_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        out_ports = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            out_ports[8*k +: 8] = port_q[k];
    end

    assign rf_rd_data  = rf_q[rf_rd_sel];
    assign sp          = sp_q;
    assign mem_wr_req  = req_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = data_q;
    assign mem_err     = err_q;

endmodule
